// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one clocked write port,
// optional hardwired zero register, optional write-to-read bypass and a busy scoreboard.
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rd_addr0,
   input  logic [ADDR_W-1:0] rd_addr1,
   output logic [DATA_W-1:0] rd_data0,
   output logic [DATA_W-1:0] rd_data1,
   output logic              rd_busy0,
   output logic              rd_busy1,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr,
   output logic              busy_any
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;
   logic              wr_allow;

   logic [ADDR_W-1:0] rd_addr [2];
   logic [DATA_W-1:0] rd_data [2];
   logic              rd_busy [2];

   // Writes to the hardwired zero register are dropped everywhere, including the bypass path.
   always_comb begin
      wr_allow = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
   end

   // NOTE: combinational blocks start from a full default so no path leaves a variable unassigned (no latches).
   always_comb begin
      mem_d = mem_q;
      if (wr_allow) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   // Clear on retire first, then set on issue, so a same-cycle issue keeps the register busy.
   always_comb begin
      busy_d = busy_q;
      if (wr_en) begin
         busy_d[wr_addr] = 1'b0;
      end
      if (iss_en) begin
         busy_d[iss_addr] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         busy_d[0] = 1'b0;
      end
   end

   // NOTE: the storage array is reset on purpose; the datapath relies on every register reading 0 after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q  <= '{default: '0};
         busy_q <= '0;
      end else begin
         mem_q  <= mem_d;
         busy_q <= busy_d;
      end
   end

   always_comb begin
      rd_addr[0] = rd_addr0;
      rd_addr[1] = rd_addr1;
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         rd_data[i] = mem_q[rd_addr[i]];
         rd_busy[i] = busy_q[rd_addr[i]];
         if ((BYPASS != 0) && wr_allow && (wr_addr == rd_addr[i])) begin
            rd_data[i] = wr_data;
            rd_busy[i] = 1'b0;
         end
         if ((ZERO_REG != 0) && (rd_addr[i] == '0)) begin
            rd_data[i] = '0;
            rd_busy[i] = 1'b0;
         end
      end
   end

   assign rd_data0 = rd_data[0];
   assign rd_data1 = rd_data[1];
   assign rd_busy0 = rd_busy[0];
   assign rd_busy1 = rd_busy[1];

   // Registered state only: an issue or retire this cycle shows up next cycle.
   assign busy_any = |busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: four parameter configurations driven in lockstep, expectations
// queued per step from a behavioural model plus directed constants, checked at the falling edge.
module tb_regfile_sb;

   localparam int NCFG = 4;

   // cfg0: 32/5 zero+bypass, cfg1: 16/3 plain, cfg2: 32/5 bypass only, cfg3: 16/3 zero only
   function automatic int cfg_dw(int c);
      return (c % 2 == 1) ? 16 : 32;
   endfunction
   function automatic int cfg_aw(int c);
      return (c % 2 == 1) ? 3 : 5;
   endfunction
   function automatic int cfg_zr(int c);
      return (c == 0 || c == 3) ? 1 : 0;
   endfunction
   function automatic int cfg_bp(int c);
      return (c == 0 || c == 2) ? 1 : 0;
   endfunction

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rd_addr0, rd_addr1, wr_addr, iss_addr;
   logic [31:0] wr_data;
   logic        wr_en, iss_en;

   logic [NCFG-1:0][31:0] o_d0, o_d1;
   logic [NCFG-1:0]       o_b0, o_b1, o_any;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NCFG; g++) begin : g_dut
      localparam int GDW = cfg_dw(g);
      localparam int GAW = cfg_aw(g);
      logic [GDW-1:0] d0, d1;

      regfile_sb #(
         .DATA_W  (GDW),
         .ADDR_W  (GAW),
         .ZERO_REG(cfg_zr(g)),
         .BYPASS  (cfg_bp(g))
      ) u_dut (
         .clk     (clk),
         .rst     (rst),
         .rd_addr0(rd_addr0[GAW-1:0]),
         .rd_addr1(rd_addr1[GAW-1:0]),
         .rd_data0(d0),
         .rd_data1(d1),
         .rd_busy0(o_b0[g]),
         .rd_busy1(o_b1[g]),
         .wr_en   (wr_en),
         .wr_addr (wr_addr[GAW-1:0]),
         .wr_data (wr_data[GDW-1:0]),
         .iss_en  (iss_en),
         .iss_addr(iss_addr[GAW-1:0]),
         .busy_any(o_any[g])
      );

      assign o_d0[g] = 32'(d0);
      assign o_d1[g] = 32'(d1);
   end

   typedef enum {K_D0, K_D1, K_B0, K_B1, K_ANY} kind_e;
   typedef struct {
      string       tag;
      int          cfg;
      kind_e       kind;
      logic [31:0] exp;
   } exp_t;

   exp_t        sb_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] m_mem  [NCFG][32];
   bit          m_busy [NCFG][32];

   function automatic logic [31:0] dmask(int c);
      return (cfg_dw(c) == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
   endfunction
   function automatic logic [4:0] amask(int c);
      return (cfg_aw(c) == 5) ? 5'h1F : 5'h07;
   endfunction

   function automatic bit fwd_hit(int c, logic [4:0] am);
      return (cfg_bp(c) == 1) && wr_en && ((wr_addr & amask(c)) == am);
   endfunction

   function automatic logic [31:0] exp_data(int c, logic [4:0] a);
      logic [4:0] am = a & amask(c);
      if (cfg_zr(c) == 1 && am == 5'd0) return 32'd0;
      if (fwd_hit(c, am)) return wr_data & dmask(c);
      return m_mem[c][am];
   endfunction

   function automatic logic [31:0] exp_busy(int c, logic [4:0] a);
      logic [4:0] am = a & amask(c);
      if (cfg_zr(c) == 1 && am == 5'd0) return 32'd0;
      if (fwd_hit(c, am)) return 32'd0;
      return {31'd0, m_busy[c][am]};
   endfunction

   function automatic logic [31:0] exp_any(int c);
      bit r = 1'b0;
      for (int i = 0; i < 32; i++) r |= m_busy[c][i];
      return {31'd0, r};
   endfunction

   function automatic logic [31:0] observed(int c, kind_e k);
      case (k)
         K_D0:    return o_d0[c];
         K_D1:    return o_d1[c];
         K_B0:    return {31'd0, o_b0[c]};
         K_B1:    return {31'd0, o_b1[c]};
         default: return {31'd0, o_any[c]};
      endcase
   endfunction

   task automatic push_const(string tag, int c, kind_e k, logic [31:0] v);
      exp_t e;
      e.tag = tag; e.cfg = c; e.kind = k; e.exp = v;
      sb_q.push_back(e);
   endtask

   task automatic push_model(string tag);
      for (int c = 0; c < NCFG; c++) begin
         push_const(tag, c, K_D0, exp_data(c, rd_addr0));
         push_const(tag, c, K_D1, exp_data(c, rd_addr1));
         push_const(tag, c, K_B0, exp_busy(c, rd_addr0));
         push_const(tag, c, K_B1, exp_busy(c, rd_addr1));
         push_const(tag, c, K_ANY, exp_any(c));
      end
   endtask

   task automatic check_all();
      exp_t        e;
      logic [31:0] obs;
      while (sb_q.size() > 0) begin
         e   = sb_q.pop_front();
         obs = observed(e.cfg, e.kind);
         n_tests++;
         assert (obs === e.exp) else begin
            n_fail++;
            $error("FAIL %s cfg%0d %s: observed=%h expected=%h", e.tag, e.cfg, e.kind.name(), obs, e.exp);
         end
      end
   endtask

   task automatic model_clock();
      logic [4:0] wa, ia;
      for (int c = 0; c < NCFG; c++) begin
         wa = wr_addr & amask(c);
         ia = iss_addr & amask(c);
         if (rst) begin
            for (int i = 0; i < 32; i++) begin
               m_mem[c][i]  = 32'd0;
               m_busy[c][i] = 1'b0;
            end
         end else begin
            if (wr_en && !(cfg_zr(c) == 1 && wa == 5'd0)) m_mem[c][wa] = wr_data & dmask(c);
            if (wr_en) m_busy[c][wa] = 1'b0;
            if (iss_en) m_busy[c][ia] = 1'b1;
            if (cfg_zr(c) == 1) m_busy[c][0] = 1'b0;
         end
      end
   endtask

   task automatic drive(bit r, bit we, logic [4:0] wa, logic [31:0] wd,
                        bit ie, logic [4:0] ia, logic [4:0] a0, logic [4:0] a1);
      rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
      iss_en = ie; iss_addr = ia; rd_addr0 = a0; rd_addr1 = a1;
   endtask

   task automatic step(string tag);
      push_model(tag);
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   initial begin
      for (int c = 0; c < NCFG; c++)
         for (int i = 0; i < 32; i++) begin
            m_mem[c][i]  = 32'd0;
            m_busy[c][i] = 1'b0;
         end

      drive(1, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      model_clock();
      #1;
      step("rst_init");

      // 1: reset clears data written before it
      drive(0, 1, 5, 32'hDEAD_BEEF, 0, 0, 5, 5);
      step("s1_wr");
      drive(1, 0, 0, 0, 0, 0, 5, 5);
      step("s1_rst");
      drive(0, 0, 0, 0, 0, 0, 5, 5);
      for (int c = 0; c < NCFG; c++) begin
         push_const("s1_after_d", c, K_D0, 32'd0);
         push_const("s1_after_b", c, K_B0, 32'd0);
         push_const("s1_after_any", c, K_ANY, 32'd0);
      end
      step("s1_after");

      // 2: write/read, same-cycle bypass versus next-cycle visibility
      drive(0, 1, 7, 32'h1234_5678, 0, 0, 7, 7);
      push_const("s2_byp", 0, K_D0, 32'h1234_5678);
      push_const("s2_nobyp", 1, K_D1, 32'd0);
      step("s2_same");
      drive(0, 0, 0, 0, 0, 0, 7, 7);
      push_const("s2_next", 0, K_D1, 32'h1234_5678);
      push_const("s2_next", 1, K_D0, 32'h0000_5678);
      step("s2_next");

      // 3: zero register ignores writes and issues
      drive(0, 1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0);
      push_const("s3_same", 0, K_D0, 32'd0);
      step("s3_same");
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      push_const("s3_d", 0, K_D0, 32'd0);
      push_const("s3_b", 0, K_B0, 32'd0);
      push_const("s3_any", 0, K_ANY, 32'd0);
      push_const("s3_d_nz", 1, K_D0, 32'h0000_FFFF);
      push_const("s3_b_nz", 1, K_B0, 32'd1);
      step("s3_after");
      drive(0, 1, 0, 32'd0, 0, 0, 0, 0);
      step("s3_clean");

      // 4: scoreboard issue / retire timing on r3
      drive(0, 0, 0, 0, 1, 3, 3, 3);
      push_const("s4_T", 0, K_B0, 32'd0);
      step("s4_T");
      drive(0, 0, 0, 0, 0, 0, 3, 3);
      push_const("s4_T1", 0, K_B0, 32'd1);
      push_const("s4_T1_any", 0, K_ANY, 32'd1);
      step("s4_T1");
      step("s4_T2");
      step("s4_T3");
      drive(0, 1, 3, 32'h0000_00A5, 0, 0, 3, 3);
      push_const("s4_T4_b", 0, K_B0, 32'd0);
      push_const("s4_T4_d", 0, K_D0, 32'h0000_00A5);
      push_const("s4_T4_b_nobyp", 1, K_B0, 32'd1);
      push_const("s4_T4_any", 0, K_ANY, 32'd1);
      step("s4_T4");
      drive(0, 0, 0, 0, 0, 0, 3, 3);
      push_const("s4_T5_b", 0, K_B0, 32'd0);
      push_const("s4_T5_any", 0, K_ANY, 32'd0);
      push_const("s4_T5_d_nobyp", 1, K_D0, 32'h0000_00A5);
      step("s4_T5");

      // 5: same-cycle issue and retire on r9: set wins
      drive(0, 0, 0, 0, 1, 9, 9, 9);
      step("s5_iss");
      drive(0, 1, 9, 32'h0000_0055, 1, 9, 9, 9);
      push_const("s5_same_b", 0, K_B0, 32'd0);
      step("s5_both");
      drive(0, 0, 0, 0, 0, 0, 9, 9);
      push_const("s5_d", 0, K_D0, 32'h0000_0055);
      push_const("s5_b", 0, K_B0, 32'd1);
      push_const("s5_b_c1", 1, K_B1, 32'd1);
      step("s5_after");

      // 6: reset wins over a concurrent write
      drive(0, 0, 0, 0, 1, 2, 2, 4);
      step("s6_iss2");
      drive(0, 0, 0, 0, 1, 4, 2, 4);
      step("s6_iss4");
      drive(1, 1, 2, 32'h0000_0077, 0, 0, 2, 4);
      step("s6_rst");
      drive(0, 0, 0, 0, 0, 0, 2, 4);
      for (int c = 0; c < NCFG; c++) begin
         push_const("s6_d0", c, K_D0, 32'd0);
         push_const("s6_b0", c, K_B0, 32'd0);
         push_const("s6_b1", c, K_B1, 32'd0);
         push_const("s6_any", c, K_ANY, 32'd0);
      end
      step("s6_after");

      // Mixed traffic against the model
      for (int n = 0; n < 80; n++) begin
         drive(($urandom_range(0, 19) == 0), $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
               $urandom_range(0, 1), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
